// File: rtl/snoop_bus_pkg.sv
// Shared types and constants for the snooping-bus controller and its arbiter.
package snoop_bus_pkg;

   typedef enum logic [2:0] {
      IDLE, SNOOP, RESP, WB, MEMRD, FILL, DONE
   } state_e;

   typedef enum logic [1:0] {
      CMD_NONE   = 2'b00,
      CMD_RDMISS = 2'b01,
      CMD_WRMISS = 2'b10,
      CMD_INV    = 2'b11
   } cmd_e;

   // Port-index width sized for the largest supported fabric, so one package serves every N_PROC.
   localparam int MAX_PROC = 8;
   localparam int IDX_W    = $clog2(MAX_PROC);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester found scanning upward from last+1 modulo N.
module rr_arbiter
   import snoop_bus_pkg::*;
#(
   parameter int N = 3
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] last_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o
);

   logic found;

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves a value held (no latch).
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!found && req_i[i] && ((int'(last_i) + k) % N == i)) begin
               gnt_o[i] = 1'b1;
               idx_o    = IDX_W'(i);
               found    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// N-port MSI snooping-bus controller: round-robin grant, one snoop phase,
// cache-to-cache supply with memory write-back, or memory fill.
module snoop_bus_ctrl
   import snoop_bus_pkg::*;
#(
   parameter int N_PROC = 3,
   parameter int TAG_W  = 12,
   parameter int DATA_W = 16
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_PROC-1:0]        req,
   input  logic [2*N_PROC-1:0]      req_cmd,
   input  logic [TAG_W*N_PROC-1:0]  req_tag,
   output logic [N_PROC-1:0]        grant,
   output logic                     bus_valid,
   output logic [1:0]               bus_cmd,
   output logic [TAG_W-1:0]         bus_tag,
   input  logic [N_PROC-1:0]        snoop_shared,
   input  logic [N_PROC-1:0]        snoop_supply,
   input  logic [DATA_W*N_PROC-1:0] snoop_data,
   output logic                     mem_rd,
   output logic                     mem_wr,
   output logic [TAG_W-1:0]         mem_tag,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   input  logic                     mem_ack,
   output logic                     fill_valid,
   output logic [DATA_W-1:0]        fill_data,
   output logic                     fill_shared,
   output logic [N_PROC-1:0]        done
);

   state_e              state_q;
   logic [IDX_W-1:0]    last_q, idx_q;
   logic [N_PROC-1:0]   grant_q, done_q;
   cmd_e                cmd_q;
   logic [TAG_W-1:0]    tag_q, bus_tag_q, mem_tag_q;
   logic [1:0]          bus_cmd_q;
   logic                bus_valid_q, mem_rd_q, mem_wr_q, fill_valid_q, fill_shared_q, shared_q;
   logic [DATA_W-1:0]   mem_wdata_q, fill_data_q;

   logic [N_PROC-1:0]   req_valid_d, arb_gnt, shared_m, supply_m;
   logic [IDX_W-1:0]    arb_idx;
   cmd_e                win_cmd_d;
   logic [TAG_W-1:0]    win_tag_d;
   logic [DATA_W-1:0]   supply_data_d;

   rr_arbiter #(.N(N_PROC)) u_arb (
      .req_i  (req_valid_d),
      .last_i (last_q),
      .gnt_o  (arb_gnt),
      .idx_o  (arb_idx)
   );

   // The granted port never snoops its own transaction.
   assign shared_m = snoop_shared & ~grant_q;
   assign supply_m = snoop_supply & ~grant_q;

   always_comb begin
      req_valid_d   = '0;
      win_cmd_d     = CMD_NONE;
      win_tag_d     = '0;
      supply_data_d = '0;
      for (int i = 0; i < N_PROC; i++) begin
         req_valid_d[i] = req[i] && (req_cmd[2*i +: 2] != CMD_NONE);
         if (arb_gnt[i]) begin
            win_cmd_d = cmd_e'(req_cmd[2*i +: 2]);
            win_tag_d = req_tag[TAG_W*i +: TAG_W];
         end
      end
      for (int i = N_PROC - 1; i >= 0; i--) begin
         if (supply_m[i]) supply_data_d = snoop_data[DATA_W*i +: DATA_W];
      end
   end

   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, whatever the order below.
      if (reset) begin
         state_q       <= IDLE;
         last_q        <= IDX_W'(N_PROC - 1);
         idx_q         <= '0;
         grant_q       <= '0;
         cmd_q         <= CMD_NONE;
         tag_q         <= '0;
         shared_q      <= 1'b0;
         bus_valid_q   <= 1'b0;
         bus_cmd_q     <= '0;
         bus_tag_q     <= '0;
         mem_rd_q      <= 1'b0;
         mem_wr_q      <= 1'b0;
         mem_tag_q     <= '0;
         mem_wdata_q   <= '0;
         fill_valid_q  <= 1'b0;
         fill_data_q   <= '0;
         fill_shared_q <= 1'b0;
         done_q        <= '0;
      end else begin
         case (state_q)
            IDLE: if (|req_valid_d) begin
               grant_q     <= arb_gnt;
               idx_q       <= arb_idx;
               cmd_q       <= win_cmd_d;
               tag_q       <= win_tag_d;
               bus_valid_q <= 1'b1;
               bus_cmd_q   <= win_cmd_d;
               bus_tag_q   <= win_tag_d;
               state_q     <= SNOOP;
            end
            SNOOP: begin
               bus_valid_q <= 1'b0;
               bus_cmd_q   <= '0;
               bus_tag_q   <= '0;
               state_q     <= RESP;
            end
            RESP: begin
               shared_q <= |(shared_m | supply_m);
               if (cmd_q == CMD_INV) begin
                  done_q  <= grant_q;
                  state_q <= DONE;
               end else if (|supply_m) begin
                  mem_wr_q    <= 1'b1;
                  mem_tag_q   <= tag_q;
                  mem_wdata_q <= supply_data_d;
                  state_q     <= WB;
               end else begin
                  mem_rd_q  <= 1'b1;
                  mem_tag_q <= tag_q;
                  state_q   <= MEMRD;
               end
            end
            WB: if (mem_ack) begin
               mem_wr_q      <= 1'b0;
               mem_tag_q     <= '0;
               mem_wdata_q   <= '0;
               fill_valid_q  <= 1'b1;
               fill_data_q   <= mem_wdata_q;
               fill_shared_q <= (cmd_q == CMD_RDMISS) && shared_q;
               state_q       <= FILL;
            end
            MEMRD: if (mem_ack) begin
               mem_rd_q      <= 1'b0;
               mem_tag_q     <= '0;
               fill_valid_q  <= 1'b1;
               fill_data_q   <= mem_rdata;
               fill_shared_q <= (cmd_q == CMD_RDMISS) && shared_q;
               state_q       <= FILL;
            end
            FILL: begin
               fill_valid_q  <= 1'b0;
               fill_data_q   <= '0;
               fill_shared_q <= 1'b0;
               done_q        <= grant_q;
               state_q       <= DONE;
            end
            DONE: begin
               done_q  <= '0;
               grant_q <= '0;
               last_q  <= idx_q;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign grant       = grant_q;
   assign bus_valid   = bus_valid_q;
   assign bus_cmd     = bus_cmd_q;
   assign bus_tag     = bus_tag_q;
   assign mem_rd      = mem_rd_q;
   assign mem_wr      = mem_wr_q;
   assign mem_tag     = mem_tag_q;
   assign mem_wdata   = mem_wdata_q;
   assign fill_valid  = fill_valid_q;
   assign fill_data   = fill_data_q;
   assign fill_shared = fill_shared_q;
   assign done        = done_q;

endmodule
